// File: rtl/cpu_core_param_pkg.sv
// cpu_core_param_pkg
// Shared definitions for the parametrised accumulator core: FSM state
// encodings, 4-bit opcode constants and the decode helper that tells
// whether an opcode is followed by an operand word.
package cpu_core_param_pkg;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_OPERAND = 2'd1,
        ST_EXEC    = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_LDB = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_STA = 4'h5;
    localparam logic [3:0] OP_OUT = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_JC  = 4'h9;
    localparam logic [3:0] OP_LDI = 4'hA;
    localparam logic [3:0] OP_JNZ = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hF;

    // True for opcodes that consume one operand word following the opcode.
    function automatic logic has_operand(input logic [3:0] op);
        case (op)
            OP_LDA, OP_LDB, OP_STA, OP_JMP,
            OP_JZ, OP_JC, OP_LDI, OP_JNZ: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_core_param_alu_flags.sv
// cpu_alu_flags
// Combinational add/subtract unit with carry and zero flags.
// Ports:
//   a, b    : operands (WIDTH bits)
//   sub     : 0 = a+b, 1 = a-b
//   result  : arithmetic result modulo 2^WIDTH
//   carry   : carry out on add; "no borrow" (a >= b) on subtract
//   zero    : result == 0
module cpu_alu_flags #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] b_eff;

    // Subtraction is a + ~b + 1, so the carry out is set exactly when no
    // borrow occurs.
    always_comb begin
        b_eff = sub ? ~b : b;
        sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    end

    assign result = sum[WIDTH-1:0];
    assign carry  = sum[WIDTH];
    assign zero   = (sum[WIDTH-1:0] == '0);

endmodule

// File: rtl/cpu_core_param.sv
// cpu_core_param
// Multi-cycle accumulator CPU with a point-to-point memory port that
// accepts wait states, registered carry/zero flags and a handshaked output.
// Ports:
//   clk, reset            : rising-edge clock, async active-high reset
//   mem_addr/mem_rd/mem_wr: memory request, held while mem_ready=0
//   mem_wdata             : store data (always A)
//   mem_rdata/mem_ready   : read data and access completion
//   out_data/out_valid    : value produced by OUT
//   out_ready             : consumer accepts out_data
//   halted                : core executed HLT
//   pc                    : program counter (debug view)
//   dbg_state             : current FSM state (debug view)
//
// Output handshake: out_data is transferred on any rising edge where
// out_valid & out_ready are both 1; out_valid and out_data hold steady
// until that edge, and the handshake keeps running while halted.
module cpu_core_param
    import cpu_core_param_pkg::*;
#(
    parameter int          DATA_WIDTH = 8,
    parameter int          ADDR_WIDTH = 8,
    parameter int unsigned PC_RESET   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  halted,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [1:0]            dbg_state
);

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    // Only the opcode nibble of IR is kept; the upper IR bits carry no meaning.
    logic [3:0]            op_q;
    logic [DATA_WIDTH-1:0] opr_q;
    logic                  c_q;
    logic                  z_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_valid_q;

    logic [ADDR_WIDTH-1:0] opr_addr;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_carry;
    logic                  alu_zero;
    logic                  jump_taken;
    logic                  mem_rd_d;
    logic                  mem_wr_d;
    logic [ADDR_WIDTH-1:0] mem_addr_d;

    assign opr_addr = opr_q[ADDR_WIDTH-1:0];
    assign pc_inc   = pc_q + ADDR_WIDTH'(1);

    cpu_alu_flags #(
        .WIDTH (DATA_WIDTH)
    ) u_alu (
        .a      (a_q),
        .b      (b_q),
        .sub    (op_q == OP_SUB),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    // Conditional jumps look at flags left behind by earlier instructions.
    always_comb begin
        jump_taken = 1'b0;
        case (op_q)
            OP_JMP:  jump_taken = 1'b1;
            OP_JZ:   jump_taken = z_q;
            OP_JC:   jump_taken = c_q;
            OP_JNZ:  jump_taken = ~z_q;
            default: jump_taken = 1'b0;
        endcase
    end

    // Memory requests decode from registered state only, so they stay
    // stable across wait cycles. Read and write are mutually exclusive.
    always_comb begin
        mem_rd_d   = 1'b0;
        mem_wr_d   = 1'b0;
        mem_addr_d = pc_q;
        case (state_q)
            ST_FETCH, ST_OPERAND: mem_rd_d = 1'b1;
            ST_EXEC: begin
                if (op_q == OP_LDA || op_q == OP_LDB) begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = opr_addr;
                end else if (op_q == OP_STA) begin
                    mem_wr_d   = 1'b1;
                    mem_addr_d = opr_addr;
                end
            end
            default: ;
        endcase
    end

    // Gating with reset kills an in-flight access the moment reset rises.
    assign mem_rd    = mem_rd_d & ~reset;
    assign mem_wr    = mem_wr_d & ~reset;
    assign mem_addr  = mem_addr_d;
    assign mem_wdata = a_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign halted    = (state_q == ST_HALT);
    assign pc        = pc_q;
    assign dbg_state = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_FETCH;
            pc_q        <= ADDR_WIDTH'(PC_RESET);
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            opr_q       <= '0;
            c_q         <= 1'b0;
            z_q         <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            // Acceptance clears valid; a capture below in the same cycle wins.
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                ST_FETCH: begin
                    if (mem_ready) begin
                        op_q    <= mem_rdata[3:0];
                        pc_q    <= pc_inc;
                        state_q <= has_operand(mem_rdata[3:0]) ? ST_OPERAND : ST_EXEC;
                    end
                end

                ST_OPERAND: begin
                    if (mem_ready) begin
                        opr_q   <= mem_rdata;
                        pc_q    <= pc_inc;
                        state_q <= ST_EXEC;
                    end
                end

                ST_EXEC: begin
                    state_q <= ST_FETCH;
                    case (op_q)
                        OP_LDA: begin
                            if (mem_ready) begin
                                a_q <= mem_rdata;
                                z_q <= (mem_rdata == '0);
                            end else begin
                                state_q <= ST_EXEC;
                            end
                        end
                        OP_LDB: begin
                            if (mem_ready) begin
                                b_q <= mem_rdata;
                            end else begin
                                state_q <= ST_EXEC;
                            end
                        end
                        OP_STA: begin
                            if (!mem_ready) begin
                                state_q <= ST_EXEC;
                            end
                        end
                        OP_ADD, OP_SUB: begin
                            a_q <= alu_result;
                            c_q <= alu_carry;
                            z_q <= alu_zero;
                        end
                        OP_LDI: begin
                            a_q <= opr_q;
                            z_q <= (opr_q == '0);
                        end
                        OP_JMP, OP_JZ, OP_JC, OP_JNZ: begin
                            if (jump_taken) begin
                                pc_q <= opr_addr;
                            end
                        end
                        OP_OUT: begin
                            // Wait for the previous value to drain before capturing.
                            if (!out_valid_q) begin
                                out_data_q  <= a_q;
                                out_valid_q <= 1'b1;
                            end else begin
                                state_q <= ST_EXEC;
                            end
                        end
                        OP_HLT:  state_q <= ST_HALT;
                        default: ;  // NOP and illegal opcodes C-E
                    endcase
                end

                ST_HALT: state_q <= ST_HALT;

                default: state_q <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_core_param.sv
// tb_cpu_core_param
// Directed bench for cpu_core_param: a behavioural RAM, an output-port
// scoreboard and a linear sequence of small programs with hand-computed
// expectations.
module tb_cpu_core_param;

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] mem_addr;
    logic       mem_rd;
    logic       mem_wr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       halted;
    logic [7:0] pc;
    logic [1:0] dbg_state;

    cpu_core_param #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (8),
        .PC_RESET   (0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .halted    (halted),
        .pc        (pc),
        .dbg_state (dbg_state)
    );

    // ---------------- memory model ----------------
    logic [7:0] mem_ram [0:255];
    logic       ld_clr = 1'b0;
    logic       ld_en = 1'b0;
    logic [7:0] ld_addr = 8'h00;
    logic [7:0] ld_data = 8'h00;
    int         wr_count = 0;

    assign mem_rdata = mem_ram[mem_addr];

    always @(posedge clk) begin
        if (ld_clr) begin
            for (int i = 0; i < 256; i++) mem_ram[i] <= 8'h00;
            wr_count <= 0;
        end else if (ld_en) begin
            mem_ram[ld_addr] <= ld_data;
        end else if (mem_wr && mem_ready) begin
            mem_ram[mem_addr] <= mem_wdata;
            wr_count <= wr_count + 1;
        end
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    int halt_acc = 0;
    int both_acc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [7:0] exp_v;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL out_unexpected observed=%0h expected=none", out_data);
            end else begin
                exp_v = exp_q.pop_front();
                check("out_data_accepted", {24'h0, out_data}, {24'h0, exp_v});
            end
        end
        if (halted && (mem_rd || mem_wr)) halt_acc <= halt_acc + 1;
        if (mem_rd && mem_wr) both_acc <= both_acc + 1;
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds the core in reset and clears RAM.
    task automatic begin_load();
        reset = 1'b1;
        mem_ready = 1'b1;
        ld_clr = 1'b1;
        tick(1);
        ld_clr = 1'b0;
    endtask

    task automatic put(input logic [7:0] a, input logic [7:0] d);
        ld_addr = a;
        ld_data = d;
        ld_en = 1'b1;
        tick(1);
        ld_en = 1'b0;
    endtask

    task automatic release_reset();
        reset = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset state
        begin_load();
        check("rst_pc", pc, 8'h00);
        check("rst_halted", halted, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_mem_rd", mem_rd, 1'b0);
        check("rst_mem_wr", mem_wr, 1'b0);
        check("rst_state", dbg_state, S_FETCH);

        // T1: LDI 5; OUT; HLT
        put(8'h00, 8'h0A); put(8'h01, 8'h05); put(8'h02, 8'h06); put(8'h03, 8'h0F);
        out_ready = 1'b1;
        exp_q.push_back(8'h05);
        release_reset();
        tick(4);
        check("t1_valid_before_out", out_valid, 1'b0);
        check("t1_state_exec_out", dbg_state, S_EXEC);
        tick(1);
        check("t1_out_valid", out_valid, 1'b1);
        check("t1_out_data", out_data, 8'h05);
        tick(1);
        check("t1_valid_pulse_end", out_valid, 1'b0);
        check("t1_not_halted_c6", halted, 1'b0);
        tick(1);
        check("t1_halted_c7", halted, 1'b1);
        check("t1_pc", pc, 8'h04);
        tick(4);
        check("t1_still_halted", dbg_state, S_HALT);

        // T2: LDA 20; LDB 21; ADD; STA 22; LDB 22; SUB; OUT; HLT
        begin_load();
        put(8'h00, 8'h01); put(8'h01, 8'h20); put(8'h02, 8'h02); put(8'h03, 8'h21);
        put(8'h04, 8'h03); put(8'h05, 8'h05); put(8'h06, 8'h22); put(8'h07, 8'h02);
        put(8'h08, 8'h22); put(8'h09, 8'h04); put(8'h0A, 8'h06); put(8'h0B, 8'h0F);
        put(8'h20, 8'hF0); put(8'h21, 8'h20);
        exp_q.push_back(8'h00);
        release_reset();
        tick(8);
        check("t2_add_a", dut.a_q, 8'h10);
        check("t2_add_c", dut.c_q, 1'b1);
        check("t2_add_z", dut.z_q, 1'b0);
        tick(2);
        check("t2_sta_wr", mem_wr, 1'b1);
        check("t2_sta_rd", mem_rd, 1'b0);
        check("t2_sta_addr", mem_addr, 8'h22);
        check("t2_sta_wdata", mem_wdata, 8'h10);
        tick(1);
        check("t2_ram22", mem_ram[8'h22], 8'h10);
        check("t2_wr_count", wr_count, 1);
        tick(5);
        check("t2_sub_a", dut.a_q, 8'h00);
        check("t2_sub_z", dut.z_q, 1'b1);
        check("t2_sub_c", dut.c_q, 1'b1);
        tick(4);
        check("t2_halted", halted, 1'b1);

        // T3a: LDI 0; JZ 30 -> taken
        begin_load();
        put(8'h00, 8'h0A); put(8'h01, 8'h00); put(8'h02, 8'h08); put(8'h03, 8'h30);
        put(8'h30, 8'h0F);
        release_reset();
        tick(6);
        check("t3a_jz_taken_pc", pc, 8'h30);
        tick(2);
        check("t3a_halt_at_30", halted, 1'b1);

        // T3b: LDI 1; JZ 30 -> falls through
        begin_load();
        put(8'h00, 8'h0A); put(8'h01, 8'h01); put(8'h02, 8'h08); put(8'h03, 8'h30);
        put(8'h04, 8'h0F);
        release_reset();
        tick(6);
        check("t3b_jz_not_taken_pc", pc, 8'h04);

        // T3c: LDI FF; LDB 40 (=01); ADD; JC 30 -> taken
        begin_load();
        put(8'h00, 8'h0A); put(8'h01, 8'hFF); put(8'h02, 8'h02); put(8'h03, 8'h40);
        put(8'h04, 8'h03); put(8'h05, 8'h09); put(8'h06, 8'h30); put(8'h07, 8'h0F);
        put(8'h30, 8'h0F); put(8'h40, 8'h01);
        release_reset();
        tick(8);
        check("t3c_add_wrap_a", dut.a_q, 8'h00);
        tick(3);
        check("t3c_jc_taken_pc", pc, 8'h30);

        // T3d: LDI 1; JNZ 30 -> taken
        begin_load();
        put(8'h00, 8'h0A); put(8'h01, 8'h01); put(8'h02, 8'h0B); put(8'h03, 8'h30);
        put(8'h30, 8'h0F);
        release_reset();
        tick(6);
        check("t3d_jnz_taken_pc", pc, 8'h30);

        // T4: three wait cycles during the FETCH of LDA 50
        begin_load();
        put(8'h00, 8'h01); put(8'h01, 8'h50); put(8'h02, 8'h0F); put(8'h50, 8'h77);
        mem_ready = 1'b0;
        release_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("t4_wait_rd", mem_rd, 1'b1);
            check("t4_wait_addr", mem_addr, 8'h00);
            check("t4_wait_state", dbg_state, S_FETCH);
        end
        mem_ready = 1'b1;
        tick(2);
        check("t4_exec_pending", dbg_state, S_EXEC);
        tick(1);
        check("t4_lda_a", dut.a_q, 8'h77);
        check("t4_done_state", dbg_state, S_FETCH);
        check("t4_pc", pc, 8'h02);

        // T5: LDI 11; OUT; LDI 22; OUT; HLT with consumer stalled
        begin_load();
        put(8'h00, 8'h0A); put(8'h01, 8'h11); put(8'h02, 8'h06); put(8'h03, 8'h0A);
        put(8'h04, 8'h22); put(8'h05, 8'h06); put(8'h06, 8'h0F);
        out_ready = 1'b0;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        release_reset();
        tick(5);
        check("t5_first_valid", out_valid, 1'b1);
        check("t5_first_data", out_data, 8'h11);
        tick(5);
        check("t5_stall_state", dbg_state, S_EXEC);
        check("t5_stall_pc", pc, 8'h06);
        check("t5_held_data", out_data, 8'h11);
        check("t5_held_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        tick(1);
        check("t5_accepted_valid", out_valid, 1'b0);
        check("t5_still_exec", dbg_state, S_EXEC);
        tick(1);
        check("t5_second_valid", out_valid, 1'b1);
        check("t5_second_data", out_data, 8'h22);
        tick(2);
        check("t5_halted", halted, 1'b1);

        // T6: reset during a stalled STA with out_valid pending
        begin_load();
        put(8'h00, 8'h0A); put(8'h01, 8'h5A); put(8'h02, 8'h06); put(8'h03, 8'h05);
        put(8'h04, 8'h60);
        out_ready = 1'b0;
        release_reset();
        tick(7);
        mem_ready = 1'b0;
        tick(1);
        check("t6_sta_wr_pending", mem_wr, 1'b1);
        check("t6_out_valid_pending", out_valid, 1'b1);
        reset = 1'b1;
        #1;
        check("t6_rst_wr_drop", mem_wr, 1'b0);
        check("t6_rst_rd_low", mem_rd, 1'b0);
        check("t6_rst_pc", pc, 8'h00);
        check("t6_rst_a", dut.a_q, 8'h00);
        check("t6_rst_out_valid", out_valid, 1'b0);
        mem_ready = 1'b1;
        tick(2);
        check("t6_no_write", wr_count, 0);
        check("t6_ram60", mem_ram[8'h60], 8'h00);
        out_ready = 1'b1;

        // T7: JMP FF where FF holds NOP -> PC wraps to 00
        begin_load();
        put(8'h00, 8'h07); put(8'h01, 8'hFF); put(8'hFF, 8'h00);
        release_reset();
        tick(3);
        check("t7_jmp_pc", pc, 8'hFF);
        tick(1);
        check("t7_wrap_pc", pc, 8'h00);
        check("t7_nop_exec", dbg_state, S_EXEC);
        tick(1);
        check("t7_next_fetch_addr", mem_addr, 8'h00);
        reset = 1'b1;
        tick(1);

        // End-of-run bookkeeping
        check("sb_queue_drained", exp_q.size(), 0);
        check("no_access_while_halted", halt_acc, 0);
        check("rd_wr_exclusive", both_acc, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
